// File: rtl/bp_pkg.sv
// Shared Q-format types, saturation limits and arithmetic helpers for the backprop engine.
package bp_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned FRAC  = 24;

    typedef logic signed [WIDTH-1:0]   word_t;
    typedef logic signed [2*WIDTH-1:0] dword_t;

    localparam word_t ONE     = word_t'(1 << FRAC);
    localparam word_t SAT_MAX = word_t'({1'b0, {(WIDTH-1){1'b1}}});
    localparam word_t SAT_MIN = word_t'({1'b1, {(WIDTH-1){1'b0}}});

    // Clamp a double-width value into a single word.
    function automatic word_t sat_dw(input dword_t v);
        if (v[2*WIDTH-1:WIDTH-1] == '0 || v[2*WIDTH-1:WIDTH-1] == '1) begin
            return word_t'(v[WIDTH-1:0]);
        end
        return v[2*WIDTH-1] ? SAT_MIN : SAT_MAX;
    endfunction

    function automatic word_t fmul(input word_t a, input word_t b);
        dword_t p;
        p = dword_t'(a) * dword_t'(b);
        return sat_dw(p >>> FRAC);
    endfunction

    function automatic word_t sat_add(input word_t a, input word_t b);
        logic [WIDTH:0] s;
        s = {a[WIDTH-1], a} + {b[WIDTH-1], b};
        if (s[WIDTH] != s[WIDTH-1]) begin
            return s[WIDTH] ? SAT_MIN : SAT_MAX;
        end
        return word_t'(s[WIDTH-1:0]);
    endfunction

    function automatic word_t sat_sub(input word_t a, input word_t b);
        logic [WIDTH:0] s;
        s = {a[WIDTH-1], a} - {b[WIDTH-1], b};
        if (s[WIDTH] != s[WIDTH-1]) begin
            return s[WIDTH] ? SAT_MIN : SAT_MAX;
        end
        return word_t'(s[WIDTH-1:0]);
    endfunction

    // Flat slice index of element [hi][lo] in a row-major [*][n] bus.
    function automatic int unsigned slc(input int unsigned hi, input int unsigned lo,
                                        input int unsigned n);
        return hi * n + lo;
    endfunction

endpackage

// File: rtl/bp_grad.sv
// Combinational per-sample deltas and cost for a single-hidden-layer sigmoid MLP.
module bp_grad
    import bp_pkg::*;
#(
    parameter int unsigned N_HL_P = 3,
    parameter int unsigned N_OUT  = 2
) (
    input  logic [N_OUT*WIDTH-1:0]        a,
    input  logic [N_OUT*WIDTH-1:0]        t,
    input  logic [N_HL_P*N_OUT*WIDTH-1:0] w,
    input  logic [N_HL_P*WIDTH-1:0]       h,
    output logic [N_OUT*WIDTH-1:0]        dlto_c,
    output logic [N_HL_P*WIDTH-1:0]       dlth_c,
    output logic [WIDTH-1:0]              cost_c
);

    word_t dl [N_OUT];
    word_t ak;
    word_t e;
    word_t hj;
    word_t acc;
    word_t cs;

    always_comb begin
        dlto_c = '0;
        dlth_c = '0;
        ak     = '0;
        e      = '0;
        hj     = '0;
        acc    = '0;
        cs     = '0;
        for (int unsigned k = 0; k < N_OUT; k++) begin
            ak    = word_t'(a[k*WIDTH +: WIDTH]);
            e     = sat_sub(ak, word_t'(t[k*WIDTH +: WIDTH]));
            dl[k] = fmul(fmul(e, ak), sat_sub(ONE, ak));
            cs    = sat_add(cs, fmul(e, e));
            dlto_c[k*WIDTH +: WIDTH] = dl[k];
        end
        cost_c = cs >>> 1;
        // Back-propagate output deltas through w and the sigmoid derivative of h.
        for (int unsigned j = 0; j < N_HL_P; j++) begin
            acc = '0;
            for (int unsigned k = 0; k < N_OUT; k++) begin
                acc = sat_add(acc, fmul(word_t'(w[slc(j, k, N_OUT)*WIDTH +: WIDTH]), dl[k]));
            end
            hj = word_t'(h[j*WIDTH +: WIDTH]);
            dlth_c[j*WIDTH +: WIDTH] = fmul(fmul(acc, hj), sat_sub(ONE, hj));
        end
    end

endmodule

// File: rtl/bp_mb.sv
// Mini-batch backprop engine: per-sample deltas, saturating gradient accumulation, scaled update.
module bp_mb
    import bp_pkg::*;
#(
    parameter int unsigned N_IN       = 2,
    parameter int unsigned N_HL_P     = 3,
    parameter int unsigned N_OUT      = 2,
    parameter int unsigned LOG2_BATCH = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           rst_btch,
    input  logic                           i_valid,
    output logic                           o_ready,
    input  logic [N_IN*WIDTH-1:0]          i_k,
    input  logic [N_HL_P*WIDTH-1:0]        i_hd_a,
    input  logic [N_HL_P*N_OUT*WIDTH-1:0]  i_out_w,
    input  logic [N_OUT*WIDTH-1:0]         i_out_a,
    input  logic [N_OUT*WIDTH-1:0]         i_t,
    input  logic [WIDTH-1:0]               i_lr,
    output logic [LOG2_BATCH:0]            o_cnt,
    output logic                           o_valid,
    input  logic                           i_ready,
    output logic [WIDTH-1:0]               o_cost,
    output logic [N_OUT*WIDTH-1:0]         o_bias_o,
    output logic [N_HL_P*WIDTH-1:0]        o_bias_hd,
    output logic [N_HL_P*N_OUT*WIDTH-1:0]  o_wght_o,
    output logic [N_HL_P*N_IN*WIDTH-1:0]   o_wght_hd
);

    localparam int unsigned AW    = WIDTH + LOG2_BATCH;
    localparam int unsigned CW    = LOG2_BATCH + 1;
    localparam int unsigned BATCH = 1 << LOG2_BATCH;

    typedef logic signed [AW-1:0] acc_t;
    typedef enum logic [2:0] {IDLE, DLT, ACC, UPD, OUT} state_t;

    state_t state, state_n;

    logic [N_IN*WIDTH-1:0]         x_r, x_d;
    logic [N_HL_P*WIDTH-1:0]       h_r, h_d;
    logic [N_HL_P*N_OUT*WIDTH-1:0] w_r;
    logic [N_OUT*WIDTH-1:0]        a_r, t_r;
    logic [N_OUT*WIDTH-1:0]        dlto_r, dlto_c;
    logic [N_HL_P*WIDTH-1:0]       dlth_r, dlth_c;
    logic [WIDTH-1:0]              cost_r, cost_c;

    acc_t acc_bo [N_OUT];
    acc_t acc_bh [N_HL_P];
    acc_t acc_wo [N_HL_P*N_OUT];
    acc_t acc_wh [N_HL_P*N_IN];
    acc_t acc_c;

    logic abort;
    logic acc_clr;

    function automatic acc_t acc_add(input acc_t acc, input word_t g);
        logic [AW:0] s;
        s = {acc[AW-1], acc} + {{(AW+1-WIDTH){g[WIDTH-1]}}, g};
        if (s[AW] != s[AW-1]) begin
            return s[AW] ? acc_t'({1'b1, {(AW-1){1'b0}}}) : acc_t'({1'b0, {(AW-1){1'b1}}});
        end
        return acc_t'(s[AW-1:0]);
    endfunction

    // Batch mean always fits a word once the accumulator is shifted back down.
    function automatic word_t mean(input acc_t acc);
        acc_t m;
        m = acc >>> LOG2_BATCH;
        return word_t'(m[WIDTH-1:0]);
    endfunction

    assign abort   = rst | rst_btch;
    assign acc_clr = abort | (state == OUT && i_ready);

    bp_grad #(.N_HL_P(N_HL_P), .N_OUT(N_OUT)) u_grad (
        .a      (a_r),
        .t      (t_r),
        .w      (w_r),
        .h      (h_r),
        .dlto_c (dlto_c),
        .dlth_c (dlth_c),
        .cost_c (cost_c)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (i_valid) state_n = DLT;
            DLT:     state_n = ACC;
            ACC:     state_n = ((o_cnt + CW'(1)) == CW'(BATCH)) ? UPD : IDLE;
            UPD:     state_n = OUT;
            OUT:     if (i_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (rst_btch) state_n = IDLE;
    end

    always_ff @(posedge clk) begin
        if (abort) begin
            o_ready <= 1'b1;
            o_valid <= 1'b0;
        end else begin
            o_ready <= (state_n == IDLE);
            o_valid <= (state_n == OUT);
        end
    end

    // Sample capture and registered delta stage; no reset needed on pure datapath.
    always_ff @(posedge clk) begin
        if (state == IDLE && i_valid) begin
            x_r <= i_k;
            h_r <= i_hd_a;
            w_r <= i_out_w;
            a_r <= i_out_a;
            t_r <= i_t;
        end
        if (state == DLT) begin
            dlto_r <= dlto_c;
            dlth_r <= dlth_c;
            cost_r <= cost_c;
            h_d    <= h_r;
            x_d    <= x_r;
        end
    end

    always_ff @(posedge clk) begin
        if (acc_clr) begin
            for (int unsigned k = 0; k < N_OUT; k++) acc_bo[k] <= '0;
            for (int unsigned j = 0; j < N_HL_P; j++) acc_bh[j] <= '0;
            for (int unsigned n = 0; n < N_HL_P*N_OUT; n++) acc_wo[n] <= '0;
            for (int unsigned n = 0; n < N_HL_P*N_IN; n++) acc_wh[n] <= '0;
            acc_c <= '0;
            o_cnt <= '0;
        end else if (state == ACC) begin
            for (int unsigned k = 0; k < N_OUT; k++) begin
                acc_bo[k] <= acc_add(acc_bo[k], word_t'(dlto_r[k*WIDTH +: WIDTH]));
            end
            for (int unsigned j = 0; j < N_HL_P; j++) begin
                acc_bh[j] <= acc_add(acc_bh[j], word_t'(dlth_r[j*WIDTH +: WIDTH]));
                for (int unsigned k = 0; k < N_OUT; k++) begin
                    acc_wo[slc(j, k, N_OUT)] <= acc_add(acc_wo[slc(j, k, N_OUT)],
                        fmul(word_t'(dlto_r[k*WIDTH +: WIDTH]), word_t'(h_d[j*WIDTH +: WIDTH])));
                end
                for (int unsigned i = 0; i < N_IN; i++) begin
                    acc_wh[slc(j, i, N_IN)] <= acc_add(acc_wh[slc(j, i, N_IN)],
                        fmul(word_t'(dlth_r[j*WIDTH +: WIDTH]), word_t'(x_d[i*WIDTH +: WIDTH])));
                end
            end
            acc_c <= acc_add(acc_c, word_t'(cost_r));
            o_cnt <= o_cnt + CW'(1);
        end
    end

    // Update set is only written in UPD, so it holds across handshakes and batches.
    always_ff @(posedge clk) begin
        if (abort) begin
            o_cost    <= '0;
            o_bias_o  <= '0;
            o_bias_hd <= '0;
            o_wght_o  <= '0;
            o_wght_hd <= '0;
        end else if (state == UPD) begin
            o_cost <= mean(acc_c);
            for (int unsigned k = 0; k < N_OUT; k++) begin
                o_bias_o[k*WIDTH +: WIDTH] <= fmul(word_t'(i_lr), mean(acc_bo[k]));
            end
            for (int unsigned j = 0; j < N_HL_P; j++) begin
                o_bias_hd[j*WIDTH +: WIDTH] <= fmul(word_t'(i_lr), mean(acc_bh[j]));
            end
            for (int unsigned n = 0; n < N_HL_P*N_OUT; n++) begin
                o_wght_o[n*WIDTH +: WIDTH] <= fmul(word_t'(i_lr), mean(acc_wo[n]));
            end
            for (int unsigned n = 0; n < N_HL_P*N_IN; n++) begin
                o_wght_hd[n*WIDTH +: WIDTH] <= fmul(word_t'(i_lr), mean(acc_wh[n]));
            end
        end
    end

endmodule

// File: tb/tb_bp_mb.sv
// Randomized self-checking bench for bp_mb against an integer-arithmetic batch model.
`timescale 1ns/1ps
module tb_bp_mb;

    localparam int N_IN  = 2;
    localparam int N_HL  = 3;
    localparam int N_OUT = 2;
    localparam int W     = 32;
    localparam int LB    = 1;
    localparam int BATCH = 1 << LB;
    localparam int AW    = W + LB;
    localparam longint ONE = 64'sd1 <<< 24;

    logic clk = 1'b0;
    logic rst, rst_btch, i_valid, o_ready, o_valid, i_ready;
    logic [N_IN*W-1:0]       i_k;
    logic [N_HL*W-1:0]       i_hd_a;
    logic [N_HL*N_OUT*W-1:0] i_out_w;
    logic [N_OUT*W-1:0]      i_out_a, i_t;
    logic [W-1:0]            i_lr;
    logic [LB:0]             o_cnt;
    logic [W-1:0]            o_cost;
    logic [N_OUT*W-1:0]      o_bias_o;
    logic [N_HL*W-1:0]       o_bias_hd;
    logic [N_HL*N_OUT*W-1:0] o_wght_o;
    logic [N_HL*N_IN*W-1:0]  o_wght_hd;

    always #5 clk = ~clk;

    bp_mb #(.N_IN(N_IN), .N_HL_P(N_HL), .N_OUT(N_OUT), .LOG2_BATCH(LB)) dut (
        .clk(clk), .rst(rst), .rst_btch(rst_btch), .i_valid(i_valid), .o_ready(o_ready),
        .i_k(i_k), .i_hd_a(i_hd_a), .i_out_w(i_out_w), .i_out_a(i_out_a), .i_t(i_t),
        .i_lr(i_lr), .o_cnt(o_cnt), .o_valid(o_valid), .i_ready(i_ready), .o_cost(o_cost),
        .o_bias_o(o_bias_o), .o_bias_hd(o_bias_hd), .o_wght_o(o_wght_o), .o_wght_hd(o_wght_hd)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Sample currently being presented
    longint sx [N_IN];
    longint sh [N_HL];
    longint sw [N_HL*N_OUT];
    longint sa [N_OUT];
    longint st [N_OUT];

    // Batch sums and expected update set
    longint m_bo [N_OUT];
    longint m_bh [N_HL];
    longint m_wo [N_HL*N_OUT];
    longint m_wh [N_HL*N_IN];
    longint m_c;
    int     m_cnt;
    logic [31:0] e_bo [N_OUT];
    logic [31:0] e_bh [N_HL];
    logic [31:0] e_wo [N_HL*N_OUT];
    logic [31:0] e_wh [N_HL*N_IN];
    logic [31:0] e_c;

    function automatic longint clampb(input longint v, input int bits);
        longint hi, lo;
        hi = (longint'(1) <<< (bits - 1)) - 1;
        lo = -(longint'(1) <<< (bits - 1));
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction

    function automatic longint fm(input longint a, input longint b);
        return clampb((a * b) >>> 24, 32);
    endfunction

    function automatic longint ad(input longint a, input longint b);
        return clampb(a + b, 32);
    endfunction

    function automatic longint rnd();
        if ($urandom_range(0, 3) == 0) return longint'($signed($urandom()));
        return longint'($urandom_range(0, 32'h0400_0000)) - 64'sd33554432;
    endfunction

    task automatic model_clear();
        foreach (m_bo[k]) m_bo[k] = 0;
        foreach (m_bh[j]) m_bh[j] = 0;
        foreach (m_wo[n]) m_wo[n] = 0;
        foreach (m_wh[n]) m_wh[n] = 0;
        m_c = 0;
        m_cnt = 0;
    endtask

    task automatic expect_zero();
        foreach (e_bo[k]) e_bo[k] = '0;
        foreach (e_bh[j]) e_bh[j] = '0;
        foreach (e_wo[n]) e_wo[n] = '0;
        foreach (e_wh[n]) e_wh[n] = '0;
        e_c = '0;
    endtask

    task automatic model_sample();
        longint e, dl[N_OUT], dh, s, cst;
        cst = 0;
        for (int k = 0; k < N_OUT; k++) begin
            e     = ad(sa[k], -st[k]);
            dl[k] = fm(fm(e, sa[k]), ad(ONE, -sa[k]));
            cst   = ad(cst, fm(e, e));
            m_bo[k] = clampb(m_bo[k] + dl[k], AW);
        end
        for (int j = 0; j < N_HL; j++) begin
            s = 0;
            for (int k = 0; k < N_OUT; k++) s = ad(s, fm(sw[j*N_OUT+k], dl[k]));
            dh = fm(fm(s, sh[j]), ad(ONE, -sh[j]));
            m_bh[j] = clampb(m_bh[j] + dh, AW);
            for (int k = 0; k < N_OUT; k++)
                m_wo[j*N_OUT+k] = clampb(m_wo[j*N_OUT+k] + fm(dl[k], sh[j]), AW);
            for (int i = 0; i < N_IN; i++)
                m_wh[j*N_IN+i] = clampb(m_wh[j*N_IN+i] + fm(dh, sx[i]), AW);
        end
        m_c = clampb(m_c + (cst >>> 1), AW);
        m_cnt++;
    endtask

    task automatic model_update(input longint lr);
        foreach (e_bo[k]) e_bo[k] = 32'(fm(lr, m_bo[k] >>> LB));
        foreach (e_bh[j]) e_bh[j] = 32'(fm(lr, m_bh[j] >>> LB));
        foreach (e_wo[n]) e_wo[n] = 32'(fm(lr, m_wo[n] >>> LB));
        foreach (e_wh[n]) e_wh[n] = 32'(fm(lr, m_wh[n] >>> LB));
        e_c = 32'(m_c >>> LB);
    endtask

    task automatic rand_sample();
        foreach (sx[i]) sx[i] = rnd();
        foreach (sh[j]) sh[j] = rnd();
        foreach (sw[n]) sw[n] = rnd();
        foreach (sa[k]) sa[k] = rnd();
        foreach (st[k]) st[k] = rnd();
    endtask

    task automatic drive();
        for (int i = 0; i < N_IN; i++) i_k[i*W +: W] = 32'(sx[i]);
        for (int j = 0; j < N_HL; j++) i_hd_a[j*W +: W] = 32'(sh[j]);
        for (int n = 0; n < N_HL*N_OUT; n++) i_out_w[n*W +: W] = 32'(sw[n]);
        for (int k = 0; k < N_OUT; k++) begin
            i_out_a[k*W +: W] = 32'(sa[k]);
            i_t[k*W +: W]     = 32'(st[k]);
        end
    endtask

    task automatic check_outputs(input string tag);
        for (int k = 0; k < N_OUT; k++) chk({tag, "_bias_o"}, o_bias_o[k*W +: W], e_bo[k]);
        for (int j = 0; j < N_HL; j++) chk({tag, "_bias_hd"}, o_bias_hd[j*W +: W], e_bh[j]);
        for (int n = 0; n < N_HL*N_OUT; n++) chk({tag, "_wght_o"}, o_wght_o[n*W +: W], e_wo[n]);
        for (int n = 0; n < N_HL*N_IN; n++) chk({tag, "_wght_hd"}, o_wght_hd[n*W +: W], e_wh[n]);
        chk({tag, "_cost"}, o_cost, e_c);
    endtask

    // Present one sample from a negedge; returns at a negedge after its ACC (plus one if last).
    task automatic send(input bit last);
        int n;
        n = 0;
        while (!o_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", 32'(o_ready), 32'd1);
        drive();
        i_valid = 1'b1;
        @(posedge clk);
        #1 i_valid = 1'b0;
        model_sample();
        repeat (3) @(negedge clk);
        chk("cnt", 32'(o_cnt), 32'(m_cnt));
        chk("valid_early", 32'(o_valid), 32'd0);
        chk("ready_after_acc", 32'(o_ready), last ? 32'd0 : 32'd1);
        if (last) begin
            @(negedge clk);
            chk("valid_rise", 32'(o_valid), 32'd1);
        end
    endtask

    task automatic ack();
        i_ready = 1'b1;
        @(posedge clk);
        #1 i_ready = 1'b0;
        model_clear();
        @(negedge clk);
        chk("valid_drop", 32'(o_valid), 32'd0);
        chk("cnt_clr", 32'(o_cnt), 32'd0);
        chk("ready_idle", 32'(o_ready), 32'd1);
        check_outputs("hold");
    endtask

    task automatic run_batch(input longint lr, input string tag);
        for (int b = 0; b < BATCH; b++) begin
            rand_sample();
            if (b == BATCH - 1) i_lr = 32'(lr);
            send(b == BATCH - 1);
        end
        model_update(lr);
        check_outputs(tag);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1);
    end

    initial begin
        longint lr;
        rst = 1'b1; rst_btch = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
        i_k = '0; i_hd_a = '0; i_out_w = '0; i_out_a = '0; i_t = '0; i_lr = '0;
        model_clear();
        expect_zero();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_ready", 32'(o_ready), 32'd1);
        chk("rst_cnt", 32'(o_cnt), 32'd0);
        check_outputs("rst");

        // Directed: a=0.5, t=0, h=0.5, w=1.0, x=1.0
        foreach (sx[i]) sx[i] = ONE;
        foreach (sh[j]) sh[j] = ONE / 2;
        foreach (sw[n]) sw[n] = ONE;
        foreach (sa[k]) sa[k] = ONE / 2;
        foreach (st[k]) st[k] = 0;
        i_lr = 32'h0100_0000;
        send(1'b0);
        send(1'b1);
        model_update(ONE);
        chk("dir_bias_o", o_bias_o[31:0], 32'h0020_0000);
        chk("dir_bias_hd", o_bias_hd[31:0], 32'h0010_0000);
        chk("dir_wght_o", o_wght_o[31:0], 32'h0010_0000);
        chk("dir_wght_hd", o_wght_hd[31:0], 32'h0010_0000);
        chk("dir_cost", o_cost, 32'h0040_0000);
        check_outputs("dir");
        ack();

        // Same batch at lr=0.5, then back-pressure in OUT
        i_lr = 32'h0080_0000;
        send(1'b0);
        send(1'b1);
        model_update(ONE / 2);
        chk("half_bias_o", o_bias_o[31:0], 32'h0010_0000);
        chk("half_cost", o_cost, 32'h0040_0000);
        check_outputs("half");
        rand_sample();
        drive();
        i_valid = 1'b1;
        i_lr = $urandom();
        repeat (10) begin
            @(negedge clk);
            chk("bp_ready", 32'(o_ready), 32'd0);
            chk("bp_valid", 32'(o_valid), 32'd1);
            chk("bp_bias_o", o_bias_o[31:0], e_bo[0]);
        end
        i_valid = 1'b0;
        chk("bp_cnt", 32'(o_cnt), 32'(BATCH));
        check_outputs("bp");
        ack();

        // Batch abort after the first sample
        rand_sample();
        send(1'b0);
        rst_btch = 1'b1;
        @(posedge clk);
        #1 rst_btch = 1'b0;
        model_clear();
        expect_zero();
        @(negedge clk);
        chk("abort_cnt", 32'(o_cnt), 32'd0);
        chk("abort_ready", 32'(o_ready), 32'd1);
        chk("abort_valid", 32'(o_valid), 32'd0);
        check_outputs("abort");
        run_batch(longint'($urandom_range(0, 32'h0100_0000)), "post_abort");
        ack();

        // Random batches
        for (int r = 0; r < 8; r++) begin
            lr = longint'($urandom_range(0, 32'h0100_0000));
            run_batch(lr, "rand");
            ack();
        end

        // Saturation: a=127.0, t=-127.0
        for (int b = 0; b < BATCH; b++) begin
            rand_sample();
            foreach (sa[k]) sa[k] = 127 * ONE;
            foreach (st[k]) st[k] = -127 * ONE;
            i_lr = 32'h0100_0000;
            send(b == BATCH - 1);
        end
        model_update(ONE);
        chk("sat_bias_o", o_bias_o[31:0], 32'h8000_0000);
        chk("sat_cost", o_cost, 32'h3FFF_FFFF);
        check_outputs("sat");
        ack();

        // Reset while the engine is in DLT
        rand_sample();
        drive();
        i_valid = 1'b1;
        @(posedge clk);
        #1 i_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        model_clear();
        expect_zero();
        @(negedge clk);
        chk("rstdlt_valid", 32'(o_valid), 32'd0);
        chk("rstdlt_ready", 32'(o_ready), 32'd1);
        chk("rstdlt_cnt", 32'(o_cnt), 32'd0);
        check_outputs("rstdlt");

        run_batch(longint'($urandom_range(0, 32'h0100_0000)), "recover");
        ack();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
